// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the pipeline skid register stage.
// Holds the occupancy state encoding and the stall counter width.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_skid_reg_en_reg.sv
// Enabled data register with synchronous active-low reset to RESET_VAL.
// Latency: 1 cycle from en to q.
// Backpressure: none; holds q whenever en is low.
module en_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register with a two-entry skid buffer and sync flush; optional stall counter under PIPE_SKID_REG_STATS_EN.
// Latency: 1 cycle from in-transfer to out_data; sustains 1 transfer/cycle.
// Backpressure: in_ready is a registered state decode, so out_ready never reaches it combinationally.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
`ifdef PIPE_SKID_REG_STATS_EN
    ,
    input  logic                   stats_clr,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    pipe_state_t      state;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] main_d;
    logic             main_en;
    logic             skid_en;

    // Flush suppresses every load so the data registers keep their last value.
    always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        if (!flush) begin
            case (state)
                PS_EMPTY: main_en = in_valid;
                PS_BUSY: begin
                    main_en = in_valid & out_ready;
                    skid_en = in_valid & ~out_ready;
                end
                PS_FULL: begin
                    main_en = out_ready;
                    main_d  = skid_q;
                end
                default: ;
            endcase
        end
    end

    en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            state     <= PS_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (in_valid) begin
                        state     <= PS_BUSY;
                        out_valid <= 1'b1;
                    end
                end
                PS_BUSY: begin
                    if (in_valid && !out_ready) begin
                        state    <= PS_FULL;
                        in_ready <= 1'b0;
                    end else if (!in_valid && out_ready) begin
                        state     <= PS_EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                PS_FULL: begin
                    if (out_ready) begin
                        state    <= PS_BUSY;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= PS_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_REG_STATS_EN
    // Counts cycles where the head is offered but not taken; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst || stats_clr)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule
